// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: mfc0 read selects, cause codes and Status bit positions.
package cp0_pkg;

  typedef enum logic [1:0] {
    MFC0_NONE = 2'b00,
    MFC0_STA  = 2'b01,
    MFC0_CAU  = 2'b10,
    MFC0_EPC  = 2'b11
  } mfc0_sel_e;

  localparam logic [31:0] CAUSE_INT = 32'h0000_0000;
  localparam logic [31:0] CAUSE_OV  = 32'h0000_0004;

  localparam int unsigned IE_BIT_DEF  = 9;
  localparam int unsigned PIE_BIT_DEF = 10;

endpackage

// File: rtl/irq_sync.sv
// External interrupt front end: synchroniser, rising-edge detect and pending latch.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Clrn,
  input  logic Ext_irq,
  input  logic Inta,
  output logic Intr
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pend_q, pend_d;
  logic                   rise;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], Ext_irq};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    // A fresh edge beats a same-cycle acknowledge so the new request survives.
    pend_d = rise | (pend_q & ~Inta);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign Intr = pend_q;

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 Status/Cause/EPC register file with mfc0 read port and interrupt front end.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] STA_RESET   = 32'h0000_0000,
  parameter int unsigned IE_BIT      = IE_BIT_DEF,
  parameter int unsigned PIE_BIT     = PIE_BIT_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Ext_irq,
  input  logic        Inta,
  output logic        Intr,
  input  logic        Wsta,
  input  logic        Wcau,
  input  logic        Wepc,
  input  logic        Mtc0,
  input  logic [31:0] Cause_in,
  input  logic [31:0] Wdata,
  input  logic [31:0] Pc,
  input  logic [31:0] Npc,
  input  logic        Eret,
  input  logic [1:0]  Mfc0,
  output logic [31:0] Rdata,
  output logic [31:0] Sta,
  output logic [31:0] Cause,
  output logic [31:0] Epc
);

  logic [31:0] sta_q, sta_d;
  logic [31:0] cau_q, cau_d;
  logic [31:0] epc_q, epc_d;
  logic        entry;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .Ext_irq(Ext_irq),
    .Inta   (Inta),
    .Intr   (Intr)
  );

  assign entry = Wepc & ~Mtc0;

  // Priority per register: exception entry, then mtc0, then eret (Status only).
  always_comb begin
    sta_d = sta_q;
    cau_d = cau_q;
    epc_d = epc_q;
    if (entry) begin
      sta_d[PIE_BIT] = sta_q[IE_BIT];
      sta_d[IE_BIT]  = 1'b0;
      epc_d          = (Cause_in == CAUSE_INT) ? Npc : Pc;
      if (Wcau) begin
        cau_d = Cause_in;
      end
    end else if (Mtc0) begin
      if (Wsta) begin
        sta_d = Wdata;
      end else if (Eret) begin
        sta_d[IE_BIT] = sta_q[PIE_BIT];
      end
      if (Wcau) begin
        cau_d = Wdata;
      end
      if (Wepc) begin
        epc_d = Wdata;
      end
    end else if (Eret) begin
      sta_d[IE_BIT] = sta_q[PIE_BIT];
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      sta_q <= STA_RESET;
      cau_q <= '0;
      epc_q <= '0;
    end else begin
      sta_q <= sta_d;
      cau_q <= cau_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    Rdata = '0;
    case (mfc0_sel_e'(Mfc0))
      MFC0_STA: Rdata = sta_q;
      MFC0_CAU: Rdata = cau_q;
      MFC0_EPC: Rdata = epc_q;
      default:  Rdata = '0;
    endcase
  end

  assign Sta   = sta_q;
  assign Cause = cau_q;
  assign Epc   = epc_q;

endmodule
